memory_ram: RTL and testbench



---
 rtl/mem_pkg.sv | 50 +++++
 rtl/bit_addr_decode.sv | 18 +
 rtl/memory_ram.sv | 94 +++++++++
 tb/tb_memory_ram.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the 8051-style internal data memory: SFR addresses,
// region decode and bit-address mapping.
package mem_pkg;

    localparam logic [7:0] SFR_P0   = 8'h80;
    localparam logic [7:0] SFR_SP   = 8'h81;
    localparam logic [7:0] SFR_TCON = 8'h88;
    localparam logic [7:0] SFR_P1   = 8'h90;
    localparam logic [7:0] SFR_P2   = 8'hA0;
    localparam logic [7:0] SFR_P3   = 8'hB0;
    localparam logic [7:0] SFR_PSW  = 8'hD0;
    localparam logic [7:0] SFR_ACC  = 8'hE0;
    localparam logic [7:0] SFR_B    = 8'hF0;

    localparam logic [7:0] BIT_BASE = 8'h20;

    typedef enum logic [1:0] {
        RegionLower,
        RegionUpper,
        RegionSfr
    } region_e;

    typedef struct packed {
        logic [7:0] byte_addr;
        logic [2:0] bit_idx;
    } bit_loc_t;

    function automatic region_e decode_byte_addr(input logic [7:0] addr, input logic indirect);
        if (!addr[7]) begin
            return RegionLower;
        end
        if (indirect) begin
            return RegionUpper;
        end
        return RegionSfr;
    endfunction

    // Bits 00h-7Fh live in RAM bytes 20h-2Fh; 80h-FFh map onto SFRs whose address ends in 0 or 8.
    function automatic bit_loc_t decode_bit_addr(input logic [7:0] bit_addr);
        bit_loc_t loc;
        loc.bit_idx = bit_addr[2:0];
        if (bit_addr[7]) begin
            loc.byte_addr = {bit_addr[7:3], 3'b000};
        end else begin
            loc.byte_addr = BIT_BASE + {4'b0000, bit_addr[6:3]};
        end
        return loc;
    endfunction

endpackage

// File: rtl/bit_addr_decode.sv
// Combinational split of an 8051 bit address into containing byte and bit index.
module bit_addr_decode
    import mem_pkg::*;
(
    input  logic [7:0] i_bit_addr,
    output logic [7:0] o_byte_addr,
    output logic [2:0] o_bit_idx
);

    bit_loc_t w_loc;

    always_comb begin
        w_loc       = decode_bit_addr(i_bit_addr);
        o_byte_addr = w_loc.byte_addr;
        o_bit_idx   = w_loc.bit_idx;
    end

endmodule

// File: rtl/memory_ram.sv
// 8051 internal data memory: lower RAM, indirect-only upper RAM and direct-only SFR space,
// with registered byte and bit reads.
module memory_ram
    import mem_pkg::*;
#(
    parameter logic [7:0] SP_RESET   = 8'h07,
    parameter logic [7:0] PORT_RESET = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] in_data,
    input  logic       in_bit,
    input  logic       is_bit,
    input  logic [7:0] bit_addr,
    input  logic       indirect_flag,
    output logic [7:0] out,
    output logic       out_bit
);

    logic [7:0] r_lower [128];
    logic [7:0] r_upper [128];
    logic [7:0] r_sfr   [128];

    logic [7:0] w_bit_byte;
    logic [2:0] w_bit_idx;
    logic [6:0] w_sel_idx;
    region_e    w_region;
    logic [7:0] w_rd_byte;
    logic [7:0] w_wr_byte;

    bit_addr_decode u_bit_addr_decode (
        .i_bit_addr (bit_addr),
        .o_byte_addr(w_bit_byte),
        .o_bit_idx  (w_bit_idx)
    );

    // Bit operations always address RAM or SFR directly, never upper RAM.
    always_comb begin
        w_sel_idx = addr[6:0];
        w_region  = decode_byte_addr(addr, indirect_flag);
        if (is_bit) begin
            w_sel_idx = w_bit_byte[6:0];
            w_region  = decode_byte_addr(w_bit_byte, 1'b0);
        end

        case (w_region)
            RegionUpper: w_rd_byte = r_upper[w_sel_idx];
            RegionSfr:   w_rd_byte = r_sfr[w_sel_idx];
            default:     w_rd_byte = r_lower[w_sel_idx];
        endcase

        w_wr_byte = in_data;
        if (is_bit) begin
            w_wr_byte            = w_rd_byte;
            w_wr_byte[w_bit_idx] = in_bit;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) begin
                r_lower[i] <= 8'h00;
                r_upper[i] <= 8'h00;
                r_sfr[i]   <= 8'h00;
            end
            r_sfr[SFR_SP[6:0]] <= SP_RESET;
            r_sfr[SFR_P0[6:0]] <= PORT_RESET;
            r_sfr[SFR_P1[6:0]] <= PORT_RESET;
            r_sfr[SFR_P2[6:0]] <= PORT_RESET;
            r_sfr[SFR_P3[6:0]] <= PORT_RESET;
            out     <= 8'h00;
            out_bit <= 1'b0;
        end else begin
            // Reads sample the pre-write array contents, giving read-before-write.
            if (rd) begin
                out <= w_rd_byte;
                if (is_bit) begin
                    out_bit <= w_rd_byte[w_bit_idx];
                end
            end
            if (wr) begin
                case (w_region)
                    RegionUpper: r_upper[w_sel_idx] <= w_wr_byte;
                    RegionSfr:   r_sfr[w_sel_idx]   <= w_wr_byte;
                    default:     r_lower[w_sel_idx] <= w_wr_byte;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_ram.sv
// Self-checking bench for memory_ram: directed scenarios plus randomized traffic against
// a flat-array model of the 8051 internal data memory.
module tb_memory_ram;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_bit = 1'b0;
    logic       is_bit = 1'b0;
    logic [7:0] bit_addr = 8'h00;
    logic       indirect_flag = 1'b0;
    logic [7:0] out;
    logic       out_bit;

    int vectors = 0;
    int miscompares = 0;

    // Model space: 0-127 lower RAM, 128-255 upper RAM, 256-383 SFRs.
    logic [7:0] m_mem [0:383];
    logic [7:0] exp_out;
    logic       exp_bit;

    memory_ram #(
        .SP_RESET  (8'h07),
        .PORT_RESET(8'hFF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .addr         (addr),
        .rd           (rd),
        .wr           (wr),
        .in_data      (in_data),
        .in_bit       (in_bit),
        .is_bit       (is_bit),
        .bit_addr     (bit_addr),
        .indirect_flag(indirect_flag),
        .out          (out),
        .out_bit      (out_bit)
    );

    always #5 clock = ~clock;

    function automatic int byte_index(input logic [7:0] a, input logic ind);
        if (a < 8'd128) return int'(a);
        if (ind) return int'(a);
        return int'(a) + 128;
    endfunction

    function automatic int bit_byte_index(input logic [7:0] b);
        if (b < 8'd128) return 32 + int'(b) / 8;
        return (int'(b) / 8) * 8 + 128;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 384; i++) m_mem[i] = 8'h00;
        m_mem[256 + 8'h01] = 8'h07;
        m_mem[256 + 8'h00] = 8'hFF;
        m_mem[256 + 8'h10] = 8'hFF;
        m_mem[256 + 8'h20] = 8'hFF;
        m_mem[256 + 8'h30] = 8'hFF;
        exp_out = 8'h00;
        exp_bit = 1'b0;
    endtask

    // Drive one cycle of stimulus, clock it, then advance the model.
    task automatic step(input logic rst_n, input logic r, input logic w, input logic b,
                        input logic [7:0] a, input logic [7:0] ba, input logic [7:0] d,
                        input logic db, input logic ind);
        int idx;
        int pos;
        reset = rst_n; rd = r; wr = w; is_bit = b; addr = a; bit_addr = ba;
        in_data = d; in_bit = db; indirect_flag = ind;
        @(posedge clock);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            idx = b ? bit_byte_index(ba) : byte_index(a, ind);
            pos = int'(ba) % 8;
            if (r) begin
                exp_out = m_mem[idx];
                if (b) exp_bit = m_mem[idx][pos];
            end
            if (w) begin
                if (b) m_mem[idx][pos] = db;
                else m_mem[idx] = d;
            end
        end
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic byte_rd(input logic [7:0] a, input logic ind);
        step(1'b1, 1'b1, 1'b0, 1'b0, a, 8'h00, 8'h00, 1'b0, ind);
    endtask

    task automatic byte_wr(input logic [7:0] a, input logic [7:0] d, input logic ind);
        step(1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, d, 1'b0, ind);
    endtask

    task automatic bit_rd(input logic [7:0] ba);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, ba, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic bit_wr(input logic [7:0] ba, input logic v);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, ba, 8'h00, v, 1'b0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out: got %h want %h", out, 8'h00);
        end
        vectors++;
        if (out_bit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_bit: got %b want %b", out_bit, 1'b0);
        end
        byte_rd(8'h81, 1'b0);
        vectors++;
        if (out !== 8'h07) begin
            miscompares++;
            $display("FAIL reset_sp: got %h want %h", out, 8'h07);
        end
        byte_rd(8'h90, 1'b0);
        vectors++;
        if (out !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_p1: got %h want %h", out, 8'hFF);
        end
        byte_rd(8'h30, 1'b0);
        vectors++;
        if (out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ram30: got %h want %h", out, 8'h00);
        end
    endtask

    task automatic test_sfr_byte();
        byte_wr(8'h88, 8'h18, 1'b0);
        byte_rd(8'h88, 1'b0);
        vectors++;
        if (out !== 8'h18) begin
            miscompares++;
            $display("FAIL sfr_byte_read: got %h want %h", out, 8'h18);
        end
        idle();
        idle();
        vectors++;
        if (out !== 8'h18) begin
            miscompares++;
            $display("FAIL sfr_byte_hold: got %h want %h", out, 8'h18);
        end
    endtask

    task automatic test_bit_ram();
        bit_wr(8'h05, 1'b1);
        bit_rd(8'h05);
        vectors++;
        if (out_bit !== 1'b1) begin
            miscompares++;
            $display("FAIL bit_ram_read: got %b want %b", out_bit, 1'b1);
        end
        vectors++;
        if (out !== 8'h20) begin
            miscompares++;
            $display("FAIL bit_ram_byte_with_bit: got %h want %h", out, 8'h20);
        end
        byte_rd(8'h20, 1'b0);
        vectors++;
        if (out !== 8'h20) begin
            miscompares++;
            $display("FAIL bit_ram_byte_read: got %h want %h", out, 8'h20);
        end
    endtask

    task automatic test_bit_sfr();
        bit_wr(8'h8B, 1'b0);
        byte_rd(8'h88, 1'b0);
        vectors++;
        if (out !== 8'h10) begin
            miscompares++;
            $display("FAIL bit_sfr_byte: got %h want %h", out, 8'h10);
        end
        bit_rd(8'h8C);
        vectors++;
        if (out_bit !== 1'b1) begin
            miscompares++;
            $display("FAIL bit_sfr_read: got %b want %b", out_bit, 1'b1);
        end
    endtask

    task automatic test_indirect();
        byte_wr(8'h90, 8'h55, 1'b1);
        byte_wr(8'h90, 8'hAA, 1'b0);
        byte_rd(8'h90, 1'b1);
        vectors++;
        if (out !== 8'h55) begin
            miscompares++;
            $display("FAIL indirect_upper: got %h want %h", out, 8'h55);
        end
        byte_rd(8'h90, 1'b0);
        vectors++;
        if (out !== 8'hAA) begin
            miscompares++;
            $display("FAIL direct_sfr: got %h want %h", out, 8'hAA);
        end
    endtask

    task automatic test_back_to_back();
        byte_wr(8'h40, 8'h11, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h22, 1'b0, 1'b0);
        vectors++;
        if (out !== 8'h11) begin
            miscompares++;
            $display("FAIL rd_wr_old: got %h want %h", out, 8'h11);
        end
        byte_rd(8'h40, 1'b0);
        vectors++;
        if (out !== 8'h22) begin
            miscompares++;
            $display("FAIL rd_wr_new: got %h want %h", out, 8'h22);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] ba;
        for (int n = 0; n < 600; n++) begin
            // Half the traffic hits a small window so reads find earlier writes.
            if ($urandom_range(1, 0) == 1) begin
                a  = 8'(($urandom_range(1, 0) == 1 ? 8'h80 : 8'h20) + $urandom_range(15, 0));
                ba = 8'(($urandom_range(1, 0) == 1 ? 8'h80 : 8'h00) + $urandom_range(31, 0));
            end else begin
                a  = 8'($urandom_range(255, 0));
                ba = 8'($urandom_range(255, 0));
            end
            step(($urandom_range(99, 0) != 0), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), a, ba,
                 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)));
            vectors++;
            if (out !== exp_out) begin
                miscompares++;
                $display("FAIL random_out[%0d]: got %h want %h", n, out, exp_out);
            end
            vectors++;
            if (out_bit !== exp_bit) begin
                miscompares++;
                $display("FAIL random_out_bit[%0d]: got %b want %b", n, out_bit, exp_bit);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a_list [8];
        logic       i_list [8];
        logic [7:0] want [8];
        a_list = '{8'h40, 8'h88, 8'h81, 8'h80, 8'hA0, 8'hB0, 8'h90, 8'h20};
        i_list = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        want   = '{8'h00, 8'h00, 8'h07, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        byte_wr(8'h40, 8'h33, 1'b0);
        byte_wr(8'h81, 8'h50, 1'b0);
        byte_wr(8'h90, 8'h77, 1'b1);
        bit_wr(8'h01, 1'b1);
        bit_rd(8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h5A, 1'b0, 1'b0);
        vectors++;
        if (out !== 8'h00 || out_bit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h/%b want 00/0", out, out_bit);
        end
        for (int k = 0; k < 8; k++) begin
            byte_rd(a_list[k], i_list[k]);
            vectors++;
            if (out !== want[k]) begin
                miscompares++;
                $display("FAIL reset_mid_byte %h: got %h want %h", a_list[k], out, want[k]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sfr_byte();
        test_bit_ram();
        test_bit_sfr();
        test_indirect();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
